genetico_fitness: RTL and testbench
===================================

# genetico_fitness

Sequential fitness evaluator that sits directly downstream of the `genetico` evolvable-circuit array. It drives the array's `chromIn` through every input combination and samples `chromOut` after a configurable settle time. Each row is checked against a target truth table, and the block returns a match count plus an oscillation flag for the genetic-algorithm controller. Each sample is taken twice, so combinational loops in the evolved network are detected rather than silently scored.

## Interface
Parameters:
- `N_IN`, default 2: width of `chromIn`; number of rows evaluated is `ROWS = 2**N_IN`.
- `SETTLE`, default 2: cycles `chrom_in` is held before the first sample. Must be at least 1.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: begin an evaluation. Accepted only when `busy == 0`.
- `target`, in, `ROWS`: expected truth table; bit k is the expected output for input value k. Latched when `start` is accepted.
- `chrom_in`, out, `N_IN`: drives the array's `chromIn`. Registered.
- `chrom_out`, in, 1: the array's `chromOut`.
- `busy`, out, 1: evaluation in progress.
- `done`, out, 1: one-cycle pulse when the result is valid.
- `fitness`, out, `$clog2(ROWS+1)`: number of matching, stable rows. Held until the next accepted start.
- `unstable`, out, 1: at least one row oscillated. Held like `fitness`.

## Operation
- States:
  - IDLE: wait for `start`.
  - SETTLE: row counter `row`, settle counter `cnt`.
  - CHECK: second sample, then score the row.
  - DONE: one cycle.
- IDLE:
  - On `start`: latch `target` into `tgt_q`.
  - Set `row = 0`, `chrom_in = 0`, `cnt = 0`; clear `fitness` and `unstable`.
  - Go to SETTLE.
- SETTLE:
  - `cnt` increments each cycle.
  - On the edge where `cnt == SETTLE - 1`, capture `s_a = chrom_out` and go to CHECK.
- CHECK, one cycle, `s_b = chrom_out`:
  - If `s_a == s_b == tgt_q[row]`, increment `fitness`.
  - If `s_a != s_b`, set `unstable`. The row does not score.
  - If `row == ROWS-1`, go to DONE.
  - Otherwise increment `row` and `chrom_in`, clear `cnt`, and go to SETTLE.
- DONE:
  - `done = 1` and `busy = 0`; return to IDLE.
  - `start` is accepted in this cycle (`busy` is already 0). Same action as from IDLE.
- `busy = 1` in SETTLE and CHECK only.
- `chrom_in` equals `row` throughout a run. After a run it holds `ROWS-1` until the next start.
- `fitness` saturation: not possible. The maximum value is `ROWS`, and the width covers it.

## Timing
- Reset values: `busy = 0`, `done = 0`, `chrom_in = 0`, `fitness = 0`, `unstable = 0`; state IDLE.
- Per-row time: `SETTLE + 1` cycles.
- Start-to-done latency: `ROWS*(SETTLE+1)` cycles after the accepting edge. With the defaults this is 12.
- `busy` rises one cycle after the `start` edge and falls in the same cycle `done` rises.
- `start` while `busy == 1` is ignored. It is not queued.
- `target` changes after acceptance have no effect.
- Reset mid-run:
  - Takes effect on the next edge and overrides everything, including a simultaneous `start`.
  - Outputs return to their reset values.
  - No `done` pulse is produced.

## Structure
- Package `genetico_pkg`:
  - State enum `fit_state_t`: IDLE, SETTLE, CHECK, DONE.
  - Default `N_IN`.
  - `FIT_W(n) = $clog2(2**n + 1)`.
- One sub-module is natural: `genetico_settle_timer`.
  - Holds `cnt`.
  - Input `clear`; outputs `sample_a` (pulse at `cnt == SETTLE-1`) and `expired`.
- FSM, row counter and scoring stay in `genetico_fitness`.

## Test plan
All scenarios use `N_IN = 2` and `SETTLE = 2`, with a behavioural array model.

1. **Reset:** assert `rst` for 2 cycles with random inputs → all outputs 0 and state IDLE.
2. **Full match:** model `chrom_out = ^chrom_in`, `target = 4'b0110`, pulse `start` → `chrom_in` steps 0,1,2,3, three cycles each. `done` pulses 12 cycles after the start edge with `fitness = 4`, `unstable = 0`.
3. **No match:** same model, `target = 4'b1001` → `fitness = 0`, `unstable = 0`.
4. **Oscillation:** XOR model, but toggle `chrom_out` every cycle while `chrom_in == 2`; `target = 4'b0110` → `fitness = 3`, `unstable = 1`.
5. **Start handling:**
   - `start` pulsed at cycle 5 of a run → ignored; exactly one `done`, at cycle 12.
   - `start` held high in the `done` cycle → new run begins; `fitness` reads 0 the next cycle and `busy = 1`.
6. **Reset mid-run:** `rst` at cycle 7 → next cycle `busy = 0` and `chrom_in = 0`; no `done` within 20 cycles without a new `start`.

Source files
------------

// File: rtl/genetico_pkg.sv
// Shared types and sizing helpers for the genetico fitness evaluator.
package genetico_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } fit_state_t;

    localparam int N_IN_DEFAULT = 2;

    // Fitness width must hold every value from 0 up to 2**n matching rows.
    function automatic int FIT_W(input int n);
        return $clog2((2 ** n) + 1);
    endfunction

endpackage

// File: rtl/genetico_settle_timer.sv
// Settle counter: counts held cycles of chrom_in and flags the first-sample cycle.
module genetico_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sample_a,
    output logic expired
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired  = (cnt_q == LAST);
    assign sample_a = !clear && expired;

endmodule

// File: rtl/genetico_fitness.sv
// Walks chrom_in through every input row, double-samples chrom_out per row and
// scores it against the target truth table, flagging rows that oscillate.
module genetico_fitness
    import genetico_pkg::*;
#(
    parameter int N_IN   = N_IN_DEFAULT,
    parameter int SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [(2**N_IN)-1:0]      target,
    output logic [N_IN-1:0]           chrom_in,
    input  logic                      chrom_out,
    output logic                      busy,
    output logic                      done,
    output logic [FIT_W(N_IN)-1:0]    fitness,
    output logic                      unstable
);

    localparam int ROWS = 2 ** N_IN;
    localparam int FW   = FIT_W(N_IN);
    localparam logic [N_IN-1:0] ROW_LAST = N_IN'(ROWS - 1);
    localparam logic [N_IN-1:0] ROW_ONE  = N_IN'(1);
    localparam logic [FW-1:0]   FIT_ONE  = FW'(1);

    fit_state_t        state_q, state_d;
    logic [N_IN-1:0]   row_q, row_d;
    logic [ROWS-1:0]   tgt_q, tgt_d;
    logic              sa_q, sa_d;
    logic [FW-1:0]     fit_q, fit_d;
    logic              unst_q, unst_d;
    logic              sample_a;
    logic              expired;

    genetico_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != ST_SETTLE),
        .sample_a (sample_a),
        .expired  (expired)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tgt_d   = tgt_q;
        sa_d    = sa_q;
        fit_d   = fit_q;
        unst_d  = unst_q;
        unique case (state_q)
            // DONE accepts a new start exactly like IDLE since busy is already low.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    tgt_d   = target;
                    row_d   = '0;
                    fit_d   = '0;
                    unst_d  = 1'b0;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (sample_a) begin
                    sa_d = chrom_out;
                end
                if (expired) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // A row scores only if both samples agree with each other and the target.
                if ((sa_q == chrom_out) && (chrom_out == tgt_q[row_q])) begin
                    fit_d = fit_q + FIT_ONE;
                end
                if (sa_q != chrom_out) begin
                    unst_d = 1'b1;
                end
                if (row_q == ROW_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + ROW_ONE;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            fit_q   <= '0;
            unst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            fit_q   <= fit_d;
            unst_q  <= unst_d;
        end
    end

    always_ff @(posedge clk) begin
        tgt_q <= tgt_d;
        sa_q  <= sa_d;
    end

    assign chrom_in = row_q;
    assign busy     = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done     = (state_q == ST_DONE);
    assign fitness  = fit_q;
    assign unstable = unst_q;

endmodule

// File: tb/tb_genetico_fitness.sv
// Scenario bench for genetico_fitness with a behavioural XOR array model.
module tb_genetico_fitness;
    import genetico_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] target;
    logic [1:0] chrom_in;
    logic       chrom_out;
    logic       busy;
    logic       done;
    logic [2:0] fitness;
    logic       unstable;

    logic osc_en = 1'b0;
    logic tog    = 1'b0;

    typedef struct {
        logic [2:0] fit;
        logic       unst;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    genetico_fitness #(
        .N_IN   (2),
        .SETTLE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .target    (target),
        .chrom_in  (chrom_in),
        .chrom_out (chrom_out),
        .busy      (busy),
        .done      (done),
        .fitness   (fitness),
        .unstable  (unstable)
    );

    always #5 clk = ~clk;

    // Array model: XOR of inputs, or a free-running toggle on row 2 when oscillating.
    always @(posedge clk) tog <= ~tog;
    assign chrom_out = (osc_en && chrom_in == 2'd2) ? tog : ^chrom_in;

    // Accept a start, then wait (bounded) for done while tracing busy/chrom_in.
    task automatic start_and_wait(input logic [3:0] tgt, output int lat, output bit seq_ok);
        @(negedge clk);
        start  = 1'b1;
        target = tgt;
        @(negedge clk);
        start  = 1'b0;
        target = $urandom;
        lat    = 0;
        seq_ok = 1'b1;
        while (!done && lat < 40) begin
            if (busy !== 1'b1 || chrom_in !== 2'(lat / 3)) seq_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            start  = 1'($urandom);
            target = 4'($urandom);
        end
        @(negedge clk);
        n_checks++;
        e.fit = 3'd0;
        if ({busy, done, chrom_in, fitness, unstable} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b chrom_in=%0d fitness=%0d unstable=%b, want all 0",
                     busy, done, chrom_in, fitness, unstable);
        end
        n_checks++;
        if (dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE);
        end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_pattern(input string name, input logic [3:0] tgt, input logic osc,
                                input logic [2:0] efit, input logic eunst);
        int   lat;
        bit   seq_ok;
        exp_t e;
        exp_t got;
        osc_en = osc;
        got.fit  = efit;
        got.unst = eunst;
        sb_q.push_back(got);
        start_and_wait(tgt, lat, seq_ok);
        n_checks++;
        if (lat !== 12) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want 12", name, lat);
        end
        n_checks++;
        if (!seq_ok) begin
            n_fail++;
            $display("FAIL %s_row_sequence: got chrom_in/busy off the 0,0,0,1,1,1,2,2,2,3,3,3 walk want busy=1 throughout", name);
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue want one entry", name);
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if (done !== 1'b1 || fitness !== e.fit || unstable !== e.unst || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_result: got done=%b busy=%b fitness=%0d unstable=%b want done=1 busy=0 fitness=%0d unstable=%b",
                         name, done, busy, fitness, unstable, e.fit, e.unst);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || chrom_in !== 2'd3 || fitness !== efit || unstable !== eunst) begin
            n_fail++;
            $display("FAIL %s_hold: got done=%b busy=%b chrom_in=%0d fitness=%0d unstable=%b want 0 0 3 %0d %b",
                     name, done, busy, chrom_in, fitness, unstable, efit, eunst);
        end
        osc_en = 1'b0;
    endtask

    task automatic test_start_ignored();
        int   n_done = 0;
        int   first  = -1;
        exp_t e;
        e.fit  = 3'd4;
        e.unst = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        start  = 1'b1;
        target = 4'b0110;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 4) begin
                start  = 1'b1;
                target = 4'b1001;
            end
            if (k == 5) start = 1'b0;
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first < 0) begin
                    first = k;
                    e = sb_q.pop_front();
                    n_checks++;
                    if (fitness !== e.fit || unstable !== e.unst) begin
                        n_fail++;
                        $display("FAIL ignored_start_result: got fitness=%0d unstable=%b want %0d %b",
                                 fitness, unstable, e.fit, e.unst);
                    end
                end
            end
        end
        n_checks++;
        if (n_done !== 1 || first !== 12) begin
            n_fail++;
            $display("FAIL ignored_start_done: got %0d pulses first at %0d want 1 pulse at 12", n_done, first);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   seq_ok;
        exp_t e;
        e.fit  = 3'd4;
        e.unst = 1'b0;
        sb_q.push_back(e);
        start_and_wait(4'b0110, lat, seq_ok);
        e = sb_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || fitness !== e.fit) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b fitness=%0d want 1 %0d", done, fitness, e.fit);
        end
        e.fit  = 3'd0;
        e.unst = 1'b0;
        sb_q.push_back(e);
        start  = 1'b1;
        target = 4'b1001;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (fitness !== 3'd0 || busy !== 1'b1 || chrom_in !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_restart: got fitness=%0d busy=%b chrom_in=%0d want 0 1 0", fitness, busy, chrom_in);
        end
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (lat !== 12 || fitness !== e.fit || unstable !== e.unst) begin
            n_fail++;
            $display("FAIL b2b_second: got latency=%0d fitness=%0d unstable=%b want 12 %0d %b",
                     lat, fitness, unstable, e.fit, e.unst);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done = 0;
        @(negedge clk);
        start  = 1'b1;
        target = 4'b0110;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || chrom_in !== 2'd0 || fitness !== 3'd0 || done !== 1'b0 || dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b chrom_in=%0d fitness=%0d done=%b want 0 0 0 0 idle",
                     busy, chrom_in, fitness, done);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d pulses want 0", n_done);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        target = 4'd0;
        test_reset();
        test_pattern("full_match", 4'b0110, 1'b0, 3'd4, 1'b0);
        test_pattern("no_match", 4'b1001, 1'b0, 3'd0, 1'b0);
        test_pattern("oscillation", 4'b0110, 1'b1, 3'd3, 1'b1);
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
